// File: rtl/hamming_tx_pkg.sv
// Shared types and constants for the Hamming(7,4) transmit serializer.
package hamming_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codeword positions (1-based) that carry parity bits
    localparam int unsigned POS_P1 = 1;
    localparam int unsigned POS_P2 = 2;
    localparam int unsigned POS_P4 = 4;

    // Codeword width
    localparam int unsigned CW_W = 7;

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder.
// data = {d1,d2,d3,d4}; code[k-1] holds codeword position k,
// positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
module hamming74_enc
    import hamming_tx_pkg::*;
(
    input  logic [3:0]      data,
    output logic [CW_W-1:0] code
);

    logic d1, d2, d3, d4;

    assign d1 = data[3];
    assign d2 = data[2];
    assign d3 = data[1];
    assign d4 = data[0];

    // Place data bits and compute the three parity bits
    always_comb begin
        code             = '0;
        code[POS_P1 - 1] = d1 ^ d2 ^ d4;
        code[POS_P2 - 1] = d1 ^ d3 ^ d4;
        code[2]          = d1;
        code[POS_P4 - 1] = d2 ^ d3 ^ d4;
        code[4]          = d2;
        code[5]          = d3;
        code[6]          = d4;
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) transmit serializer: encodes a nibble on an accepted start
// and shifts the codeword out, position 1 first, one bit per DIVISOR clocks.
// Optional macro HAMMING_ERR_INJECT_EN adds err_pos to flip one codeword
// position for demo purposes.
module hamming_tx_serializer
    import hamming_tx_pkg::*;
#(
    parameter int unsigned DIVISOR = 50_000_000,
    parameter int unsigned CNT_W   = 26
) (
    input  logic            clk_board,
    input  logic            rst,
    input  logic [3:0]      d_in,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [2:0]      err_pos,
`endif
    input  logic            start,
    output logic            tx_bit,
    output logic            tx_frame,
    output logic            busy,
    output logic            done,
    output logic [CW_W-1:0] code_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW_W-1:0]   code_q, code_d;
    logic              tx_bit_q, tx_bit_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CW_W-1:0]   enc_code;
    logic [CW_W-1:0]   err_mask;

    hamming74_enc u_enc (
        .data (d_in),
        .code (enc_code)
    );

    // Single-bit error mask selected by err_pos (0 = no error)
    always_comb begin
        err_mask = '0;
`ifdef HAMMING_ERR_INJECT_EN
        if (err_pos != 3'd0) begin
            err_mask = CW_W'(1) << (err_pos - 3'd1);
        end
`endif
    end

    // Next state, counters and registered outputs; outputs are derived from
    // the next-state values so they line up with the state they describe
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        tx_bit_d = 1'b0;
        frame_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d  = enc_code ^ err_mask;
                    idx_d   = 3'd1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            SEND: begin
                tx_bit_d = code_d[idx_d - 3'd1];
                frame_d  = 1'b1;
                busy_d   = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_board or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            tx_bit_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            tx_bit_q <= tx_bit_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_frame = frame_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign code_out = code_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench for hamming_tx_serializer: two instances (DIVISOR=2
// and DIVISOR=1) share stimulus; a cycle-level expected-trace model is
// compared against both on every falling edge.
module tb_hamming_tx_serializer;

    localparam int DIV0 = 2;
    localparam int DIV1 = 1;

    typedef struct packed {
        logic bitv;
        logic frame;
        logic busy;
        logic done;
    } exp_t;
    typedef exp_t expq_t[$];

    logic       clk;
    logic       rst;
    logic [3:0] d_in;
    logic       start;
    logic [2:0] err_pos;

    logic       tx_bit0, frame0, busy0, done0;
    logic       tx_bit1, frame1, busy1, done1;
    logic [6:0] code0, code1;

    int n_checks = 0;
    int n_fail   = 0;

    expq_t      q0, q1;
    logic [6:0] ce0, ce1;

    hamming_tx_serializer #(.DIVISOR(DIV0), .CNT_W(4)) u_dut0 (
        .clk_board (clk),
        .rst       (rst),
        .d_in      (d_in),
`ifdef HAMMING_ERR_INJECT_EN
        .err_pos   (err_pos),
`endif
        .start     (start),
        .tx_bit    (tx_bit0),
        .tx_frame  (frame0),
        .busy      (busy0),
        .done      (done0),
        .code_out  (code0)
    );

    hamming_tx_serializer #(.DIVISOR(DIV1), .CNT_W(1)) u_dut1 (
        .clk_board (clk),
        .rst       (rst),
        .d_in      (d_in),
`ifdef HAMMING_ERR_INJECT_EN
        .err_pos   (err_pos),
`endif
        .start     (start),
        .tx_bit    (tx_bit1),
        .tx_frame  (frame1),
        .busy      (busy1),
        .done      (done1),
        .code_out  (code1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Generic Hamming rule: parity position p covers every position j with (j & p) != 0
    function automatic logic [6:0] model_code(input logic [3:0] d, input logic [2:0] ep);
        logic [6:0] r;
        bit c[8];
        bit x;
        for (int j = 0; j < 8; j++) c[j] = 1'b0;
        c[3] = d[3];
        c[5] = d[2];
        c[6] = d[1];
        c[7] = d[0];
        for (int p = 1; p <= 4; p = p * 2) begin
            x = 1'b0;
            for (int j = 1; j <= 7; j++)
                if (((j & p) != 0) && (j != p)) x = x ^ c[j];
            c[p] = x;
        end
        if (ep != 3'd0) c[ep] = ~c[ep];
        for (int k = 1; k <= 7; k++) r[k-1] = c[k];
        return r;
    endfunction

    // Expected per-cycle outputs of one frame: 7 bits of div cycles each, then done
    function automatic expq_t build_frame(input logic [6:0] cw, input int div);
        expq_t q;
        exp_t  e;
        for (int k = 0; k < 7; k++) begin
            for (int r = 0; r < div; r++) begin
                e.bitv = cw[k]; e.frame = 1'b1; e.busy = 1'b1; e.done = 1'b0;
                q.push_back(e);
            end
        end
        e.bitv = 1'b0; e.frame = 1'b0; e.busy = 1'b1; e.done = 1'b1;
        q.push_back(e);
        return q;
    endfunction

    // Model: consume one expected cycle per edge; a start seen on an idle cycle opens a frame
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete(); q1.delete();
            ce0 = '0; ce1 = '0;
        end else begin
            if (q0.size() > 0) void'(q0.pop_front());
            else if (start) begin
                ce0 = model_code(d_in, err_pos);
                q0  = build_frame(ce0, DIV0);
            end
            if (q1.size() > 0) void'(q1.pop_front());
            else if (start) begin
                ce1 = model_code(d_in, err_pos);
                q1  = build_frame(ce1, DIV1);
            end
        end
    end

    // Compare both DUTs against the model every cycle
    always @(negedge clk) begin
        exp_t e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : '0;
        e1 = (q1.size() > 0) ? q1[0] : '0;
        chk("dut0_outputs", {28'd0, tx_bit0, frame0, busy0, done0}, {28'd0, e0});
        chk("dut1_outputs", {28'd0, tx_bit1, frame1, busy1, done1}, {28'd0, e1});
        chk("dut0_code_out", {25'd0, code0}, {25'd0, ce0});
        chk("dut1_code_out", {25'd0, code1}, {25'd0, ce1});
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && (busy0 || busy1); i++) @(negedge clk);
        chk("idle_timeout", {30'd0, busy0, busy1}, 32'd0);
    endtask

    // Launch one frame on both DUTs and measure the selected one
    task automatic run_frame(input string name, input logic [3:0] d, input logic [6:0] exp_code,
                             input bit sel, input bit pulse_mid);
        int         div, fc, done_cyc;
        logic [6:0] bits;
        logic       fr, bt, dn;
        div = sel ? DIV1 : DIV0;
        fc = 0; done_cyc = 0; bits = '0;
        d_in = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            fr = sel ? frame1 : frame0;
            bt = sel ? tx_bit1 : tx_bit0;
            dn = sel ? done1 : done0;
            if (fr) begin
                if ((fc % div) == 0) bits[fc / div] = bt;
                fc++;
            end
            if (dn) done_cyc = c;
            if (pulse_mid && c == 3) begin start = 1'b1; d_in = ~d; end
            if (pulse_mid && c == 4) start = 1'b0;
            @(negedge clk);
        end
        chk({name, "_done_cycle"}, done_cyc, 7 * div + 1);
        chk({name, "_frame_len"}, fc, 7 * div);
        chk({name, "_bits"}, {25'd0, bits}, {25'd0, exp_code});
        chk({name, "_code_out"}, {25'd0, sel ? code1 : code0}, {25'd0, exp_code});
        chk({name, "_no_refire"}, {31'd0, sel ? busy1 : busy0}, 32'd0);
        wait_idle();
    endtask

    initial begin
        int dn0, dn1;
        rst = 1'b0; start = 1'b1; d_in = 4'b1111; err_pos = 3'd0;

        // Model pins
        chk("model_1011", {25'd0, model_code(4'b1011, 3'd0)}, 32'h66);
        chk("model_0000", {25'd0, model_code(4'b0000, 3'd0)}, 32'h00);
        chk("model_1111", {25'd0, model_code(4'b1111, 3'd0)}, 32'h7F);
        chk("model_0001", {25'd0, model_code(4'b0001, 3'd0)}, 32'h4B);
        chk("model_err3", {25'd0, model_code(4'b1011, 3'd3)}, 32'h62);

        // Reset held with start high
        repeat (3) @(negedge clk);
        chk("reset_busy0", {31'd0, busy0}, 32'd0);
        chk("reset_code0", {25'd0, code0}, 32'd0);
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);

        // Encoding and timing
        run_frame("enc1011_div2", 4'b1011, 7'h66, 1'b0, 1'b0);
        run_frame("enc1011_div1", 4'b1011, 7'h66, 1'b1, 1'b0);
        run_frame("enc0000", 4'b0000, 7'h00, 1'b0, 1'b0);
        run_frame("enc1111", 4'b1111, 7'h7F, 1'b0, 1'b0);
        run_frame("enc0001", 4'b0001, 7'h4B, 1'b0, 1'b0);
        run_frame("enc0001_div1", 4'b0001, 7'h4B, 1'b1, 1'b0);

        // Start and d_in changes mid-frame are ignored
        run_frame("midstart", 4'b1011, 7'h66, 1'b0, 1'b1);

        // Start held: frames repeat through DONE + one IDLE cycle
        d_in = 4'b0001; start = 1'b1;
        @(negedge clk);
        dn0 = 0; dn1 = 0;
        for (int c = 1; c <= 50; c++) begin
            if (done0) dn0++;
            if (done1) dn1++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_done_count0", dn0, 3);
        chk("held_done_count1", dn1, 5);
        wait_idle();

        // Asynchronous reset mid-frame
        d_in = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_dut0", {24'd0, tx_bit0, frame0, busy0, done0, code0[3:0]}, 32'd0);
        chk("async_rst_code0", {25'd0, code0}, 32'd0);
        chk("async_rst_dut1", {25'd0, tx_bit1, frame1, busy1, done1, code1[2:0]}, 32'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start_busy", {30'd0, busy0, busy1}, 32'd0);
        rst = 1'b1; start = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_done", {30'd0, done0, done1}, 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
        err_pos = 3'd3;
        run_frame("inject_pos3", 4'b1011, 7'h62, 1'b0, 1'b0);
        err_pos = 3'd0;
        run_frame("inject_none", 4'b1011, 7'h66, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamming_tx_serializer.md
Name: hamming_tx_serializer

Overview:
Transmit-side counterpart of the board's routing error-correction receiver. Accepts a 4-bit data nibble and encodes it as a Hamming(7,4) codeword. Shifts the codeword out serially, one bit per DIVISOR clocks, with frame and busy/done handshake signals. Feeds the error-correcting receiver path and supports optional deliberate single-bit error injection for board-level demos.

Parameters:
DIVISOR, 50_000_000, clk_board cycles per transmitted bit; legal range >= 1 (set small, e.g. 2, for simulation)
CNT_W, 26, width of the bit-period counter; must satisfy 2^CNT_W >= DIVISOR

Ports:
clk_board  in   1      system clock, all state on rising edge
rst        in   1      reset, asynchronous, active-low
d_in       in   4      data nibble {d1,d2,d3,d4} = d_in[3:0]; sampled only on accepted start
start      in   1      request transmission; level-sampled in IDLE only
tx_bit     out  1      serial codeword bit, position 1 first
tx_frame   out  1      high while tx_bit carries a valid codeword bit
busy       out  1      high from the cycle after accepted start until done
done       out  1      single-cycle pulse after the last bit period
code_out   out  7      latched codeword; code_out[k-1] = position k (k=1..7)

Behaviour:
- Reset (rst=0, async): state=IDLE. tx_bit=0, tx_frame=0, busy=0, done=0, code_out=0. Bit counter and period counter cleared. Reset mid-frame aborts immediately; no done pulse is produced.
- Encoding: codeword positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- States: IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - busy=0, tx_frame=0, tx_bit=0.
  - If start=1 at a rising edge: latch code_out from the encoded d_in, set bit index=1, period count=0, go to SEND.
- SEND:
  - busy=1, tx_frame=1, tx_bit = code_out[idx-1].
  - Each bit is held exactly DIVISOR cycles.
  - On the period count reaching DIVISOR-1: if idx=7 go to DONE, else idx+1 and period count=0.
  - Frame length is exactly 7*DIVISOR cycles. The first bit appears on the cycle after the start edge.
- DONE:
  - One cycle only: done=1, busy=1, tx_frame=0, tx_bit=0. Then go to IDLE.
  - Back-to-back frames are possible: start high in the following IDLE cycle is accepted, giving a 1-cycle gap.
- start while busy is ignored and is not queued. d_in changes during SEND do not affect the frame in flight.
- DIVISOR=1: one bit per clock, all counters still correct, no divide-by-zero.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro: HAMMING_ERR_INJECT_EN
- With the macro: an extra input port err_pos [2:0] is added. It is sampled with d_in on an accepted start.
  - err_pos in 1..7 inverts that codeword position, both in the transmitted bit and in code_out.
  - err_pos=0 injects no error.
- Without the macro: the port is absent and the codeword is always clean.

Decomposition:
- Package hamming_tx_pkg holds:
  - state enum {IDLE, SEND, DONE}
  - position constants POS_P1=1, POS_P2=2, POS_P4=4
  - codeword width CW_W=7
- One combinational sub-module, hamming74_enc (4-bit in, 7-bit out). It is shared with the receiver's syndrome check for reuse.
- The FSM, counters and shift selection stay in the top.

Test Plan:
- Reset check: hold rst=0 with start=1 -> all outputs 0, busy stays 0. Assert rst=0 mid-SEND -> outputs clear asynchronously, no done pulse.
- Encoding of 1011: d_in=4'b1011, start, DIVISOR=2 -> code_out=7'b1100110 (0x66). tx_bit sequence (pos1..7) = 0,1,1,0,0,1,1, each bit 2 cycles. done pulses at cycle 15 after start.
- Encoding corners: d_in=4'b0000 -> 0x00; 4'b1111 -> 0x7F; 4'b0001 -> 0x4B. tx_frame is high exactly 7*DIVISOR cycles in each case.
- Handshake: pulse start again and toggle d_in mid-frame -> frame unchanged, no second frame. Start held high continuously -> frames repeat with a 1-cycle DONE gap.
- DIVISOR=1: d_in=4'b1011 -> 7 consecutive bits 0110011, done at cycle 8.
- With HAMMING_ERR_INJECT_EN: d_in=4'b1011, err_pos=3 -> code_out=0x62 and transmitted position 3 = 0. err_pos=0 -> 0x66.
